recupera_operandos: RTL and testbench

- Bit-serial inverse of the sum/difference datapath: takes a 9-bit sum s1 = a+b and a 9-bit difference s2 = a-b, and recovers the original 8-bit operands a and b.
- s2 is two's complement, with its top bit being the final borrow.
- Computes a = (s1+s2)/2 and b = (s1-s2)/2 one bit per clock, LSB first.
- Uses valid/ready handshakes on both sides. Sits downstream of the adder/subtractor in checker and loop-back test paths.

---
 rtl/recupera_operandos.sv | 147 ++++++++++++++
 tb/tb_recupera_operandos.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/recupera_operandos.sv
// rtl/recupera_operandos.sv - bit-serial recovery of operands a, b from s1=a+b and s2=a-b
//
// Recovers a = (s1+s2)/2 and b = (s1-s2)/2 one bit per clock, LSB first,
// over an internal word of N = WIDTH+3 bits so that 2a and 2b never overflow.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   s1/s2 present
//   in_ready   block can accept an operand pair (IDLE only)
//   s1         unsigned sum a+b, WIDTH+1 bits
//   s2         two's-complement difference a-b, WIDTH+1 bits (MSB = borrow)
//   out_valid  a_out/b_out/err valid (DONE only)
//   out_ready  consumer accepts result
//   a_out      recovered a, WIDTH bits
//   b_out      recovered b, WIDTH bits
//   err        pair is inconsistent
//
// Optional feature macro: RECUPERA_ERR_CHECK_EN
//   defined   : err flags odd sums/differences and out-of-range a or b
//   undefined : err is tied to 0 and no check logic is built

module recupera_operandos #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   s1,
  input  logic [WIDTH:0]   s2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             err
);

  localparam int N  = WIDTH + 3;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nx;
  logic [N-1:0]    x, y, p, q;
  logic            cs, cd;
  logic [CW-1:0]   cnt;

  logic            p_bit, q_bit, cs_nx, cd_nx, y_inv;
  logic [N-1:0]    p_nx, q_nx;
  logic            last;
  logic            err_nx;

  // Two serial full adders: P = X + Y, Q = X + ~Y (+1 via cd preset to 1).
  always_comb begin
    y_inv = ~y[0];
    p_bit = x[0] ^ y[0] ^ cs;
    cs_nx = (x[0] & y[0]) | (x[0] & cs) | (y[0] & cs);
    q_bit = x[0] ^ y_inv ^ cd;
    cd_nx = (x[0] & y_inv) | (x[0] & cd) | (y_inv & cd);
    p_nx  = {p_bit, p[N-1:1]};
    q_nx  = {q_bit, q[N-1:1]};
  end

  assign last = (cnt == CW'(N-1));

`ifdef RECUPERA_ERR_CHECK_EN
  // Odd word means s1/s2 parity mismatch; any bit above WIDTH means the
  // operand is negative or does not fit in WIDTH bits.
  assign err_nx = p_nx[0] | (|p_nx[N-1:WIDTH+1]) | q_nx[0] | (|q_nx[N-1:WIDTH+1]);
  logic unused_bits;
  assign unused_bits = ^{p[0], q[0]};
`else
  assign err_nx = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{p[0], q[0], p_nx[0], q_nx[0],
                         p_nx[N-1:WIDTH+1], q_nx[N-1:WIDTH+1]};
`endif

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      p     <= '0;
      q     <= '0;
      cs    <= 1'b0;
      cd    <= 1'b0;
      cnt   <= '0;
      a_out <= '0;
      b_out <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x   <= N'(s1);
            y   <= {{(N-WIDTH-1){s2[WIDTH]}}, s2};
            p   <= '0;
            q   <= '0;
            cs  <= 1'b0;
            cd  <= 1'b1;
            cnt <= '0;
          end
        end
        CALC: begin
          x   <= {1'b0, x[N-1:1]};
          y   <= {y[N-1], y[N-1:1]};
          p   <= p_nx;
          q   <= q_nx;
          cs  <= cs_nx;
          cd  <= cd_nx;
          cnt <= cnt + CW'(1);
          // Final edge: take the result including the bit formed this cycle.
          if (last) begin
            a_out <= p_nx[WIDTH:1];
            b_out <= q_nx[WIDTH:1];
            err   <= err_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recupera_operandos.sv
// tb/tb_recupera_operandos.sv - scoreboard bench for recupera_operandos
module tb_recupera_operandos;

  localparam int LAT = 11;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, err;
  logic [8:0] s1, s2;
  logic [7:0] a_out, b_out;

  recupera_operandos #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s1(s1), .s2(s2), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int e;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mode = 0;
  int   n_sent = 0;
  int   n_recv = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the decoded sum and difference.
  function automatic exp_t model(input logic [8:0] v1, input logic [8:0] v2, input int acc);
    exp_t r;
    int sv, sum, dif;
    sv  = $signed(v2);
    sum = int'(v1) + sv;
    dif = int'(v1) - sv;
    r.a = (sum >>> 1) & 255;
    r.b = (dif >>> 1) & 255;
`ifdef RECUPERA_ERR_CHECK_EN
    r.e = ((sum % 2) != 0 || sum < 0 || sum > 511 ||
           (dif % 2) != 0 || dif < 0 || dif > 511) ? 1 : 0;
`else
    r.e = 0;
`endif
    r.acc = acc;
    return r;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && !prev_ov && exp_q.size() > 0)
      chk("latency", cyc - exp_q[0].acc, LAT);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("a_out", int'(a_out), e.a);
        chk("b_out", int'(b_out), e.b);
        chk("err", int'(err), e.e);
        n_recv++;
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [8:0] v1, input logic [8:0] v2);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    s1 = v1;
    s2 = v2;
    @(posedge clk);
    #1;
    exp_q.push_back(model(v1, v2, cyc));
    n_sent++;
    in_valid = 1'b0;
    s1 = 9'($urandom);
    s2 = 9'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] dv1 [6];
    logic [8:0] dv2 [6];
    logic [7:0] ha, hb;
    logic       he;
    int         k;
    int         ra, rb;

    rst = 1'b1; in_valid = 1'b0; s1 = '0; s2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_a_out", int'(a_out), 0);
    chk("rst_b_out", int'(b_out), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;

    // First directed pair, in_ready must drop while busy.
    send(9'h089, 9'h03F);
    @(negedge clk);
    chk("busy_in_ready", int'(in_ready), 0);
    drain();

    dv1[0] = 9'h0CD; dv2[0] = 9'h13D;
    dv1[1] = 9'h1FE; dv2[1] = 9'h000;
    dv1[2] = 9'h000; dv2[2] = 9'h000;
    dv1[3] = 9'h003; dv2[3] = 9'h000;
    dv1[4] = 9'h000; dv2[4] = 9'h002;
    dv1[5] = 9'h089; dv2[5] = 9'h03F;
    for (int i = 0; i < 6; i++) send(dv1[i], dv2[i]);
    drain();

    // Backpressure: result held while out_ready=0, in_valid ignored when busy.
    mode = 2;
    send(9'h089, 9'h03F);
    in_valid = 1'b1; s1 = 9'h1FE; s2 = 9'h000;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("bp_out_valid_rise", int'(out_valid), 1);
    ha = a_out; hb = b_out; he = err;
    chk("bp_a_first", int'(ha), 100);
    chk("bp_b_first", int'(hb), 37);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_a", int'(a_out), int'(ha));
      chk("bp_hold_b", int'(b_out), int'(hb));
      chk("bp_hold_err", int'(err), int'(he));
      chk("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    mode = 0;
    drain();

    // Reset at cnt=4 of CALC discards the pair.
    send(9'h089, 9'h03F);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_sent -= exp_q.size();
    exp_q.delete();
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_a_out", int'(a_out), 0);
    chk("mid_rst_b_out", int'(b_out), 0);
    chk("mid_rst_err", int'(err), 0);
    rst = 1'b0;
    send(9'h089, 9'h03F);
    drain();

    // Random consistent pairs with random consumer stalls.
    mode = 1;
    for (int i = 0; i < 20; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      send(9'(ra + rb), 9'(ra - rb));
    end
    drain();
    mode = 0;
    repeat (3) @(negedge clk);

    chk("sent_vs_recv", n_recv, n_sent);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
